// File: rtl/ps2_keyboard_wb_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// ps2_keyboard_wb_if : level-handshake bus bundle for the PS/2 keyboard slave
// Rev 1.0
//------------------------------------------------------------------------------
interface ps2_keyboard_wb_if;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
    modport slave  (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard_wb.sv
`default_nettype none
//------------------------------------------------------------------------------
// ps2_keyboard_wb : PS/2 receiver + scan-code FIFO behind a level-handshake bus
// Optional: define KBD_PARITY_CHECK_EN to drop frames with bad odd parity.
// Rev 1.0
//------------------------------------------------------------------------------
module ps2_keyboard_wb #(
    parameter int FIFO_AW        = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    input  wire logic          PS2C,
    input  wire logic          PS2D,
    ps2_keyboard_wb_if.slave   bus,
    output logic               INT
);
    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic              r_c1, r_c2, r_c3, r_d1, r_d2;
    state_t            r_state;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [c_TW-1:0]   r_timer;
    logic              r_push;
    logic [7:0]        r_push_data;
    logic              r_err_set;

    logic [7:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]  r_count;
    logic              r_ovf, r_err, r_int_en;

    logic              w_fall, w_par_ok, w_ne, w_full, w_access, w_rd, w_wr;
    logic              w_pop, w_push_ok, w_clr_ovf, w_clr_err;
    logic [1:0]        w_addr;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    // r_c3 holds last cycle's synchronised clock so the edge test sees a clean 1->0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {r_c1, r_c2, r_c3} <= 3'b111;
            {r_d1, r_d2}       <= 2'b11;
        end else begin
            r_c1 <= PS2C;
            r_c2 <= r_c1;
            r_c3 <= r_c2;
            r_d1 <= PS2D;
            r_d2 <= r_d1;
        end
    end

    assign w_fall = r_c3 & ~r_c2;

`ifdef KBD_PARITY_CHECK_EN
    assign w_par_ok = ^{r_shift, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_parity    <= 1'b0;
            r_timer     <= '0;
            r_push      <= 1'b0;
            r_push_data <= 8'd0;
            r_err_set   <= 1'b0;
        end else begin
            r_push    <= 1'b0;
            r_err_set <= 1'b0;
            if (w_fall || r_state == S_IDLE)
                r_timer <= '0;
            else
                r_timer <= r_timer + c_TW'(1);

            case (r_state)
                S_IDLE: if (w_fall && !r_d2) begin
                    r_state  <= S_DATA;
                    r_bitcnt <= 3'd0;
                end
                S_DATA: if (w_fall) begin
                    r_shift  <= {r_d2, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7)
                        r_state <= S_PARITY;
                end
                S_PARITY: if (w_fall) begin
                    r_parity <= r_d2;
                    r_state  <= S_STOP;
                end
                default: if (w_fall) begin
                    if (r_d2 && w_par_ok) begin
                        r_push      <= 1'b1;
                        r_push_data <= r_shift;
                    end else begin
                        r_err_set   <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
            endcase

            if (r_state != S_IDLE && !w_fall && r_timer == c_TW'(TIMEOUT_CYCLES)) begin
                r_state   <= S_IDLE;
                r_err_set <= 1'b1;
            end
        end
    end

    assign w_addr    = bus.ADDR[3:2];
    assign w_access  = bus.STB & ~bus.ACK;
    assign w_rd      = w_access & ~bus.WE;
    assign w_wr      = w_access & bus.WE;
    assign w_ne      = (r_count != '0);
    assign w_full    = (r_count == (FIFO_AW + 1)'(c_DEPTH));
    assign w_pop     = w_rd && (w_addr == 2'd0) && w_ne;
    assign w_push_ok = r_push && (!w_full || w_pop);
    assign w_clr_ovf = w_wr && (w_addr == 2'd1) && bus.DAT_I[2];
    assign w_clr_err = w_wr && (w_addr == 2'd1) && bus.DAT_I[1];

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            2'd0:    if (w_ne) w_rdata = {23'd0, 1'b1, r_mem[r_rptr]};
            2'd1:    w_rdata = 32'({r_count, 5'd0, r_ovf, r_err, w_ne});
            2'd2:    w_rdata = {31'd0, r_int_en};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= r_push_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
            r_int_en  <= 1'b0;
            bus.ACK   <= 1'b0;
            bus.DAT_O <= 32'd0;
            INT       <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // hardware set takes priority over a simultaneous W1C
            r_ovf <= (r_ovf & ~w_clr_ovf) | (r_push & w_full & ~w_pop);
            r_err <= (r_err & ~w_clr_err) | r_err_set;

            if (w_wr && w_addr == 2'd2)
                r_int_en <= bus.DAT_I[0];

            if (w_access) begin
                bus.ACK <= 1'b1;
                if (!bus.WE)
                    bus.DAT_O <= w_rdata;
            end else if (bus.ACK && !bus.STB) begin
                bus.ACK <= 1'b0;
            end

            INT <= r_int_en & (w_ne | r_ovf);
        end
    end

    assign w_unused_bits = &{1'b0, bus.ADDR[31:4], bus.ADDR[1:0], bus.DAT_I[31:3], bus.DAT_I[0], r_parity};

endmodule
`default_nettype wire
